display_framebuffer: RTL and testbench

- Double-buffered pixel frame store sitting directly upstream of the display driver.
- Write side: a valid/ready pixel stream from the renderer/host, one pixel per beat, in raster order.
- Read side: answers the driver's row/column address with all segments' pixels one cycle later.
- Buffers swap only on the driver's frame_complete pulse, so the display never shows a torn frame.

---
 rtl/display_framebuffer_if.sv | 33 +++
 rtl/display_framebuffer.sv | 152 +++++++++++++++
 tb/tb_display_framebuffer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/display_framebuffer_if.sv
// rtl/display_framebuffer_if.sv - pixel write stream and driver read port of the frame store
interface display_framebuffer_if #(
    parameter int segments   = 1,
    parameter int rows       = 8,
    parameter int columns    = 32,
    parameter int cyclewidth = 8
);
    localparam int ROW_W = (rows > 1) ? $clog2(rows) : 1;
    localparam int COL_W = (columns > 1) ? $clog2(columns) : 1;
    localparam int PIX_W = 3 * cyclewidth;

    logic [ROW_W-1:0]          rd_row;
    logic [COL_W-1:0]          rd_column;
    logic [PIX_W*segments-1:0] rd_pixel;
    logic                      frame_complete;
    logic                      wr_valid;
    logic                      wr_ready;
    logic                      wr_sof;
    logic [PIX_W-1:0]          wr_data;
    logic                      front_sel;
    logic                      frame_swapped;
    logic                      wr_abort;

    modport master (
        output rd_row, rd_column, frame_complete, wr_valid, wr_sof, wr_data,
        input  rd_pixel, wr_ready, front_sel, frame_swapped, wr_abort
    );

    modport slave (
        input  rd_row, rd_column, frame_complete, wr_valid, wr_sof, wr_data,
        output rd_pixel, wr_ready, front_sel, frame_swapped, wr_abort
    );
endinterface

// File: rtl/display_framebuffer.sv
// rtl/display_framebuffer.sv - double-buffered frame store, swapped only on the driver's frame boundary
module display_framebuffer #(
    parameter int segments   = 1,
    parameter int rows       = 8,
    parameter int columns    = 32,
    parameter int cyclewidth = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    display_framebuffer_if.slave  bus
);
    localparam int PIX_W = 3 * cyclewidth;
    localparam int SEG_W = (segments > 1) ? $clog2(segments) : 1;
    localparam int ROW_W = (rows > 1) ? $clog2(rows) : 1;
    localparam int COL_W = (columns > 1) ? $clog2(columns) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(segments - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(rows - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(columns - 1);

    typedef enum logic [1:0] {IDLE, FILL, PENDING} wr_state_e;

    wr_state_e        state_q, state_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             front_sel_q, front_sel_d;
    logic             frame_swapped_q, frame_swapped_d;
    logic             wr_abort_q, wr_abort_d;

    logic             wr_ready;
    logic             wr_en;
    logic             restart;
    logic [SEG_W-1:0] wr_seg, nxt_seg;
    logic [ROW_W-1:0] wr_row, nxt_row;
    logic [COL_W-1:0] wr_col, nxt_col;
    logic             at_last;

    always_comb begin
        state_d         = state_q;
        seg_d           = seg_q;
        row_d           = row_q;
        col_d           = col_q;
        front_sel_d     = front_sel_q;
        frame_swapped_d = 1'b0;
        wr_abort_d      = 1'b0;
        wr_ready        = 1'b0;
        wr_en           = 1'b0;

        // A start-of-frame beat always lands on the first pixel, whatever the counters hold.
        restart = (state_q == IDLE) || bus.wr_sof;
        wr_seg  = restart ? '0 : seg_q;
        wr_row  = restart ? '0 : row_q;
        wr_col  = restart ? '0 : col_q;
        at_last = (wr_seg == SEG_LAST) && (wr_row == ROW_LAST) && (wr_col == COL_LAST);

        nxt_seg = wr_seg;
        nxt_row = wr_row;
        nxt_col = wr_col + COL_W'(1);
        if (wr_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = wr_row + ROW_W'(1);
            if (wr_row == ROW_LAST) begin
                nxt_row = '0;
                nxt_seg = (wr_seg == SEG_LAST) ? '0 : wr_seg + SEG_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                wr_ready = 1'b1;
                if (bus.wr_valid && bus.wr_sof) begin
                    wr_en   = 1'b1;
                    seg_d   = nxt_seg;
                    row_d   = nxt_row;
                    col_d   = nxt_col;
                    state_d = at_last ? PENDING : FILL;
                end
            end
            FILL: begin
                wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    wr_en      = 1'b1;
                    seg_d      = nxt_seg;
                    row_d      = nxt_row;
                    col_d      = nxt_col;
                    wr_abort_d = bus.wr_sof;
                    state_d    = at_last ? PENDING : FILL;
                end
            end
            PENDING: begin
                if (bus.frame_complete) begin
                    front_sel_d     = !front_sel_q;
                    frame_swapped_d = 1'b1;
                    seg_d           = '0;
                    row_d           = '0;
                    col_d           = '0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) wr_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            seg_q           <= '0;
            row_q           <= '0;
            col_q           <= '0;
            front_sel_q     <= 1'b0;
            frame_swapped_q <= 1'b0;
            wr_abort_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            seg_q           <= seg_d;
            row_q           <= row_d;
            col_q           <= col_d;
            front_sel_q     <= front_sel_d;
            frame_swapped_q <= frame_swapped_d;
            wr_abort_q      <= wr_abort_d;
        end
    end

    logic [PIX_W*segments-1:0] rd_pixel_w;

    // One RAM per segment lane; writes go to the back bank, reads to the front, so they never collide.
    for (genvar s = 0; s < segments; s++) begin : g_lane
        logic [PIX_W-1:0] mem [2][rows][columns];
        logic [PIX_W-1:0] lane_pixel_q;

        always_ff @(posedge clk) begin
            if (wr_en && (wr_seg == SEG_W'(s))) begin
                mem[!front_sel_q][wr_row][wr_col] <= bus.wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) lane_pixel_q <= '0;
            else     lane_pixel_q <= mem[front_sel_q][bus.rd_row][bus.rd_column];
        end

        assign rd_pixel_w[s*PIX_W +: PIX_W] = lane_pixel_q;
    end

    assign bus.rd_pixel      = rd_pixel_w;
    assign bus.wr_ready      = wr_ready;
    assign bus.front_sel     = front_sel_q;
    assign bus.frame_swapped = frame_swapped_q;
    assign bus.wr_abort      = wr_abort_q;
endmodule

// File: tb/tb_display_framebuffer.sv
// tb/tb_display_framebuffer.sv - scoreboard bench for display_framebuffer
module tb_display_framebuffer;
    localparam int S  = 2;
    localparam int R  = 8;
    localparam int C  = 32;
    localparam int CW = 8;
    localparam int PW = 3 * CW;
    localparam int N  = S * R * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_framebuffer_if #(.segments(S), .rows(R), .columns(C), .cyclewidth(CW)) bus ();
    display_framebuffer_if #(.segments(1), .rows(1), .columns(1), .cyclewidth(CW)) bus1 ();

    display_framebuffer #(.segments(S), .rows(R), .columns(C), .cyclewidth(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    display_framebuffer #(.segments(1), .rows(1), .columns(1), .cyclewidth(CW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int total = 0;
    int bad = 0;
    int abort_cnt = 0;

    logic [PW-1:0]    model_mem [2][N];
    bit               model_front = 1'b0;
    int               model_pos = 0;
    logic [S*PW-1:0]  exp_q [$];
    logic             rd_req = 1'b0;
    logic             rd_pend = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [S*PW-1:0] model_read(input int r, input int c);
        logic [S*PW-1:0] v;
        for (int s = 0; s < S; s++) v[s*PW +: PW] = model_mem[model_front][s*R*C + r*C + c];
        return v;
    endfunction

    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else chk("rd_pixel", bus.rd_pixel, exp_q.pop_front());
        end
        if (bus.wr_abort) abort_cnt++;
    end

    task automatic step();
        @(negedge clk);
        rd_req              = 1'b0;
        bus.wr_valid        = 1'b0;
        bus.wr_sof          = 1'b0;
        bus.frame_complete  = 1'b0;
        bus1.wr_valid       = 1'b0;
        bus1.wr_sof         = 1'b0;
        bus1.frame_complete = 1'b0;
    endtask

    task automatic issue_read(input int r, input int c);
        bus.rd_row    = 3'(r);
        bus.rd_column = 5'(c);
        rd_req        = 1'b1;
        exp_q.push_back(model_read(r, c));
    endtask

    task automatic beat(input logic sof, input logic [PW-1:0] d, output bit acc);
        bus.wr_valid = 1'b1;
        bus.wr_sof   = sof;
        bus.wr_data  = d;
        #1 acc = bus.wr_ready;
        if (acc) begin
            if (sof) model_pos = 0;
            if (model_pos < N) model_mem[!model_front][model_pos] = d;
            model_pos++;
        end
        step();
    endtask

    task automatic send(input int n, input logic [PW-1:0] base);
        bit acc;
        for (int i = 0; i < n; i++) beat(i == 0, base + PW'(i), acc);
    endtask

    task automatic pulse_fc(input string tag);
        bit exp_swap;
        exp_swap = (model_pos == N);
        bus.frame_complete = 1'b1;
        issue_read(2, 7);
        step();
        if (exp_swap) begin
            model_front = !model_front;
            model_pos   = 0;
        end
        chk({tag, "_swapped"}, bus.frame_swapped, exp_swap);
        chk({tag, "_front"}, bus.front_sel, model_front);
    endtask

    task automatic read_pts();
        issue_read(0, 0);  step();
        issue_read(2, 7);  step();
        issue_read(7, 31); step();
        issue_read(3, 5);  step();
        step();
    endtask

    initial begin
        bit acc;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) model_mem[b][i] = '0;
        bus.rd_row = '0;   bus.rd_column = '0;  bus.frame_complete = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_sof = 1'b0; bus.wr_data = '0;
        bus1.rd_row = '0;  bus1.rd_column = '0; bus1.frame_complete = 1'b0;
        bus1.wr_valid = 1'b0; bus1.wr_sof = 1'b0; bus1.wr_data = '0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_front", bus.front_sel, 1'b0);
        chk("rst_ready", bus.wr_ready, 1'b1);
        chk("rst_swapped", bus.frame_swapped, 1'b0);
        chk("rst_abort", bus.wr_abort, 1'b0);
        chk("rst_pixel", bus.rd_pixel, '0);
        chk("rst1_ready", bus1.wr_ready, 1'b1);
        issue_read(3, 5); step(); step();

        // full frame, data = beat index
        send(N, '0);
        chk("full_ready_low", bus.wr_ready, 1'b0);
        pulse_fc("full");
        issue_read(2, 7); step();
        chk("full_swap_pulse_end", bus.frame_swapped, 1'b0);
        step();
        read_pts();

        // commit while idle is ignored
        pulse_fc("idle_fc");

        // partial frame then commit: no swap
        send(100, 24'h001000);
        chk("part_ready", bus.wr_ready, 1'b1);
        pulse_fc("part");
        read_pts();

        // new sof abandons the partial frame, then a mid-frame sof restarts again
        send(40, 24'h002000);
        #2 chk("abort_prev", abort_cnt, 1);
        abort_cnt = 0;
        beat(1'b1, 24'hAA0000, acc);
        for (int i = 0; i < N - 1; i++) beat(1'b0, 24'h003000 + PW'(i), acc);
        #2 chk("abort_mid", abort_cnt, 1);
        chk("mid_ready_low", bus.wr_ready, 1'b0);
        pulse_fc("mid");
        read_pts();

        // backpressure while pending
        send(N, 24'h010000);
        for (int i = 0; i < 50; i++) begin
            beat(1'(i % 2), 24'hFFFFFF, acc);
            chk("bp_ready", acc, 1'b0);
        end
        pulse_fc("bp");
        chk("bp_ready_after", bus.wr_ready, 1'b1);
        read_pts();

        // single-pixel instance
        bus1.wr_valid = 1'b1; bus1.wr_sof = 1'b0; bus1.wr_data = 24'h111111;
        step();
        chk("one_nosof_ready", bus1.wr_ready, 1'b1);
        bus1.wr_valid = 1'b1; bus1.wr_sof = 1'b1; bus1.wr_data = 24'h123456;
        step();
        chk("one_pending", bus1.wr_ready, 1'b0);
        bus1.frame_complete = 1'b1;
        step();
        chk("one_swapped", bus1.frame_swapped, 1'b1);
        chk("one_front", bus1.front_sel, 1'b1);
        step();
        chk("one_pixel", bus1.rd_pixel, 24'h123456);
        chk("one_ready", bus1.wr_ready, 1'b1);

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
